// File: rtl/eight_bit_1_8_demux_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eight_bit_1_8_demux_reg_pkg
// Brief    : Shared widths and channel names for the byte demux and 8:1 mux.
// Revision : 1.0
// ============================================================================
package eight_bit_1_8_demux_reg_pkg;

    localparam int CH_COUNT = 8;
    localparam int DATA_W   = 8;
    localparam int SEL_W    = 3;

    localparam logic [SEL_W-1:0] CH_A = 3'd0;
    localparam logic [SEL_W-1:0] CH_B = 3'd1;
    localparam logic [SEL_W-1:0] CH_C = 3'd2;
    localparam logic [SEL_W-1:0] CH_D = 3'd3;
    localparam logic [SEL_W-1:0] CH_E = 3'd4;
    localparam logic [SEL_W-1:0] CH_F = 3'd5;
    localparam logic [SEL_W-1:0] CH_G = 3'd6;
    localparam logic [SEL_W-1:0] CH_H = 3'd7;

    function automatic logic [CH_COUNT-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [CH_COUNT-1:0] w_oh;
        w_oh      = '0;
        w_oh[sel] = 1'b1;
        return w_oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eight_bit_1_8_demux_reg_channel_reg_8.sv
`default_nettype none
// ============================================================================
// Module   : channel_reg_8
// Brief    : One 8-bit holding register with a valid flag (write beats ack).
// Revision : 1.0
// ============================================================================
module channel_reg_8
    import eight_bit_1_8_demux_reg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic              ack,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    // Clear only drops the flag; the held byte stays readable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (clr) begin
            r_valid <= 1'b0;
        end else if (wr) begin
            r_data  <= d;
            r_valid <= 1'b1;
        end else if (ack) begin
            r_valid <= 1'b0;
        end
    end

    assign q     = r_data;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/eight_bit_1_8_demux_reg.sv
`default_nettype none
// ============================================================================
// Module   : eight_bit_1_8_demux_reg
// Brief    : Registered 1-to-8 byte distributor with valid/ack per channel.
// Revision : 1.0
// ============================================================================
module eight_bit_1_8_demux_reg
    import eight_bit_1_8_demux_reg_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   in,
    input  logic                s0,
    input  logic                s1,
    input  logic                s2,
    input  logic                we,
    input  logic                auto,
    input  logic                clr,
    input  logic [CH_COUNT-1:0] ack,
    output logic                in_ready,
    output logic [DATA_W-1:0]   a,
    output logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   c,
    output logic [DATA_W-1:0]   d,
    output logic [DATA_W-1:0]   e,
    output logic [DATA_W-1:0]   f,
    output logic [DATA_W-1:0]   g,
    output logic [DATA_W-1:0]   h,
    output logic [CH_COUNT-1:0] valid,
    output logic                full,
    output logic [SEL_W-1:0]    ptr
);

    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    w_target;
    logic [CH_COUNT-1:0] w_target_oh;
    logic [CH_COUNT-1:0] w_valid;
    logic [CH_COUNT-1:0] w_wr;
    logic                w_accept;
    logic [DATA_W-1:0]   w_q [CH_COUNT];

    assign w_target    = auto ? r_ptr : {s2, s1, s0};
    assign w_target_oh = sel_to_onehot(w_target);

    // Ready never looks at the data byte, only at occupancy and ack.
    assign in_ready = ~w_valid[w_target] | ack[w_target];
    assign w_accept = we & in_ready;
    assign w_wr     = w_accept ? w_target_oh : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (w_accept && auto) begin
            r_ptr <= r_ptr + 3'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_channel
            channel_reg_8 u_channel_reg_8 (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .wr    (w_wr[gi]),
                .ack   (ack[gi]),
                .d     (in),
                .q     (w_q[gi]),
                .valid (w_valid[gi])
            );
        end
    endgenerate

    assign a     = w_q[CH_A];
    assign b     = w_q[CH_B];
    assign c     = w_q[CH_C];
    assign d     = w_q[CH_D];
    assign e     = w_q[CH_E];
    assign f     = w_q[CH_F];
    assign g     = w_q[CH_G];
    assign h     = w_q[CH_H];
    assign valid = w_valid;
    assign full  = &w_valid;
    assign ptr   = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_eight_bit_1_8_demux_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_eight_bit_1_8_demux_reg
// Brief    : Directed self-checking bench for the registered byte demux.
// Revision : 1.0
// ============================================================================
module tb_eight_bit_1_8_demux_reg;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic       s0, s1, s2;
    logic       we;
    logic       auto;
    logic       clr;
    logic [7:0] ack;
    logic       in_ready;
    logic [7:0] a, b, c, d, e, f, g, h;
    logic [7:0] valid;
    logic       full;
    logic [2:0] ptr;

    int r_compared   = 0;
    int r_mismatched = 0;

    eight_bit_1_8_demux_reg u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .s0       (s0),
        .s1       (s1),
        .s2       (s2),
        .we       (we),
        .auto     (auto),
        .clr      (clr),
        .ack      (ack),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .e        (e),
        .f        (f),
        .g        (g),
        .h        (h),
        .valid    (valid),
        .full     (full),
        .ptr      (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        r_compared++;
        if (obs !== exp) begin
            r_mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [2:0] sel);
        {s2, s1, s0} = sel;
    endtask

    initial begin
        rst_n = 1'b0; in = '0; {s2, s1, s0} = 3'd0;
        we = 1'b0; auto = 1'b0; clr = 1'b0; ack = '0;
        step();
        step();
        check("reset_data",  {a, b, c, d, e, f, g, h}, 64'h0);
        check("reset_valid", valid, 8'h00);
        check("reset_ptr",   ptr, 3'd0);
        check("reset_full",  full, 1'b0);

        // Manual write to channel f
        rst_n = 1'b1;
        set_sel(3'd5); in = 8'hA5; we = 1'b1;
        step();
        we = 1'b0;
        check("man_f",      f, 8'hA5);
        check("man_valid",  valid, 8'h20);
        check("man_others", {a, b, c, d, e, g, h}, 56'h0);

        // Back-pressure on channel c
        set_sel(3'd2); in = 8'h11; we = 1'b1;
        step();
        check("bp_first_c", c, 8'h11);
        in = 8'h22;
        #1;
        check("bp_not_ready", in_ready, 1'b0);
        step();
        check("bp_hold_c",     c, 8'h11);
        check("bp_hold_valid", valid, 8'h24);
        ack = 8'h04;
        #1;
        check("bp_ack_ready", in_ready, 1'b1);
        step();
        we = 1'b0; ack = 8'h00;
        check("bp_ack_wr_c",     c, 8'h22);
        check("bp_ack_wr_valid", valid, 8'h24);

        // Plain clear keeps data
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_valid", valid, 8'h00);
        check("clr_data",  {c, f}, 16'h22A5);

        // Auto fill of all eight channels and wrap
        auto = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in = i[7:0]; we = 1'b1;
            step();
        end
        we = 1'b0;
        check("auto_data",  {a, b, c, d, e, f, g, h}, 64'h0001020304050607);
        check("auto_full",  full, 1'b1);
        check("auto_ptr",   ptr, 3'd0);
        check("auto_valid", valid, 8'hFF);
        in = 8'h99; we = 1'b1;
        #1;
        check("auto_ninth_ready", in_ready, 1'b0);
        step();
        we = 1'b0;
        check("auto_ninth_a",   a, 8'h00);
        check("auto_ninth_ptr", ptr, 3'd0);

        // Ack and refill channel a in the same cycle
        ack = 8'h01; in = 8'hFF; we = 1'b1;
        #1;
        check("refill_ready", in_ready, 1'b1);
        step();
        ack = 8'h00; we = 1'b0;
        check("refill_a",    a, 8'hFF);
        check("refill_ptr",  ptr, 3'd1);
        check("refill_full", full, 1'b1);

        // Ack without write drops valid, keeps data; repeat ack is a no-op
        ack = 8'h80;
        step();
        check("ack_valid", valid, 8'h7F);
        check("ack_data",  h, 8'h07);
        check("ack_full",  full, 1'b0);
        step();
        ack = 8'h00;
        check("ack_idle_valid", valid, 8'h7F);

        // Clear beats a concurrent write and acks
        clr = 1'b1; we = 1'b1; ack = 8'hFF; in = 8'h55;
        step();
        clr = 1'b0; we = 1'b0; ack = 8'h00;
        check("clrpri_valid", valid, 8'h00);
        check("clrpri_ptr",   ptr, 3'd0);
        check("clrpri_data",  {a, b, c, d, e, f, g, h}, 64'hFF01020304050607);

        // Manual mode leaves the pointer alone
        auto = 1'b0; set_sel(3'd3); in = 8'h33; we = 1'b1;
        step();
        check("manhold_d",   d, 8'h33);
        check("manhold_ptr", ptr, 3'd0);
        auto = 1'b1; in = 8'h44;
        step();
        check("auto_resume_a",   a, 8'h44);
        check("auto_resume_ptr", ptr, 3'd1);

        // Reset in the middle of an auto burst
        in = 8'hAA;
        step();
        in = 8'hBB;
        step();
        check("burst_bc", {b, c}, 16'hAABB);
        check("burst_ptr", ptr, 3'd3);
        rst_n = 1'b0; in = 8'hCC;
        step();
        check("midrst_data",  {a, b, c, d, e, f, g, h}, 64'h0);
        check("midrst_valid", valid, 8'h00);
        check("midrst_ptr",   ptr, 3'd0);
        check("midrst_full",  full, 1'b0);
        rst_n = 1'b1; in = 8'hDD;
        step();
        we = 1'b0;
        check("resume_a",     a, 8'hDD);
        check("resume_valid", valid, 8'h01);
        check("resume_ptr",   ptr, 3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_compared, r_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
